// File: rtl/proc_pkg.sv
// Shared definitions for the run sequencer of the single-cycle 9-bit core.
// Contents:
//   PC_W_DEF / CYC_W_DEF : default program-counter and cycle-counter widths
//   run_state_t          : sequencer states
//   prog_base()          : maps a program index onto its ROM start address
package proc_pkg;

  localparam int PC_W_DEF  = 10;
  localparam int CYC_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } run_state_t;

  // Any index outside 0..2 falls back to program 0's base address.
  function automatic logic [PC_W_DEF-1:0] prog_base(
    input logic [1:0]          idx,
    input logic [PC_W_DEF-1:0] base0,
    input logic [PC_W_DEF-1:0] base1,
    input logic [PC_W_DEF-1:0] base2
  );
    logic [PC_W_DEF-1:0] base;
    case (idx)
      2'd1:    base = base1;
      2'd2:    base = base2;
      default: base = base0;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/run_cycle_ctr.sv
// RUN-cycle counter with watchdog compare.
// Ports:
//   Clk, Reset : clock (posedge) and asynchronous active-high reset
//   clear      : forces the count to zero on the next edge (wins over enable)
//   enable     : increments the count on the next edge
//   count      : current number of counted cycles
//   hit_limit  : high when the next increment would reach MAX_CYCLES
module run_cycle_ctr
  import proc_pkg::*;
#(
  parameter int               CYC_W      = CYC_W_DEF,
  parameter logic [CYC_W-1:0] MAX_CYCLES = 16'd1000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CYC_W-1:0] count,
  output logic             hit_limit
);

  // Comparing against MAX_CYCLES-1 lets the sequencer see the limit in the
  // same cycle that the final increment happens, so the count stops exactly
  // at MAX_CYCLES and can never wrap.
  localparam logic [CYC_W-1:0] LIMIT_M1 = MAX_CYCLES - 1'b1;

  logic [CYC_W-1:0] count_q;
  logic [CYC_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign hit_limit = (count_q == LIMIT_M1);

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer: walks the core through up to NPROG programs in ROM using the
// host Start/Ack handshake, holds the core in init at the program base,
// releases it to run until CoreDone, counts RUN cycles and flags a watchdog
// timeout.
// Ports:
//   Clk, Reset : clock (posedge) and asynchronous active-high reset
//   Start      : host request; held high keeps the core in init
//   CoreDone   : core halt flag, only looked at while running
//   CoreInit   : core PC loads ProgBase, writes blocked
//   CoreRun    : core PC advances, writes enabled
//   ProgBase   : ROM start address of the current program
//   ProgIdx    : current program number
//   Ack        : program finished (normally or by watchdog)
//   Timeout    : watchdog fired for the current program
//   CycleCt    : RUN cycles spent on the current program
module run_ctrl
  import proc_pkg::*;
#(
  parameter int               PC_W       = PC_W_DEF,
  parameter int               CYC_W      = CYC_W_DEF,
  parameter int               NPROG      = 3,
  parameter logic [PC_W-1:0]  BASE0      = 10'd0,
  parameter logic [PC_W-1:0]  BASE1      = 10'd256,
  parameter logic [PC_W-1:0]  BASE2      = 10'd512,
  parameter logic [CYC_W-1:0] MAX_CYCLES = 16'd1000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             CoreDone,
  output logic             CoreInit,
  output logic             CoreRun,
  output logic [PC_W-1:0]  ProgBase,
  output logic [1:0]       ProgIdx,
  output logic             Ack,
  output logic             Timeout,
  output logic [CYC_W-1:0] CycleCt
);

  localparam logic [1:0] LAST_IDX = 2'(NPROG - 1);

  run_state_t state_q;
  run_state_t state_d;
  logic [1:0] prog_idx_q;
  logic [1:0] prog_idx_d;
  logic       ctr_clear;
  logic       ctr_enable;
  logic       hit_limit;

  // Next-state and program-index logic. CoreDone outranks the watchdog so a
  // program finishing on its very last allowed cycle still counts as done.
  always_comb begin
    state_d    = state_q;
    prog_idx_d = prog_idx_q;
    case (state_q)
      IDLE: begin
        if (Start) state_d = INIT;
      end
      INIT: begin
        if (!Start) state_d = RUN;
      end
      RUN: begin
        if (CoreDone) begin
          state_d = DONE;
        end else if (hit_limit) begin
          state_d = FAULT;
        end
      end
      DONE, FAULT: begin
        if (Start) begin
          state_d    = INIT;
          prog_idx_d = (prog_idx_q == LAST_IDX) ? 2'd0 : prog_idx_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The counter is zeroed on the way into INIT and kept there while INIT
  // lasts; it only advances on edges taken from RUN, so DONE/FAULT freeze it.
  always_comb begin
    ctr_clear  = (state_d == INIT);
    ctr_enable = (state_q == RUN);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      prog_idx_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      prog_idx_q <= prog_idx_d;
    end
  end

  run_cycle_ctr #(
    .CYC_W      (CYC_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_cycle_ctr (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (ctr_clear),
    .enable    (ctr_enable),
    .count     (CycleCt),
    .hit_limit (hit_limit)
  );

  assign CoreInit = (state_q == INIT);
  assign CoreRun  = (state_q == RUN);
  assign Ack      = (state_q == DONE) || (state_q == FAULT);
  assign Timeout  = (state_q == FAULT);
  assign ProgIdx  = prog_idx_q;
  assign ProgBase = PC_W'(prog_base(prog_idx_q, PC_W_DEF'(BASE0),
                                    PC_W_DEF'(BASE1), PC_W_DEF'(BASE2)));

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl. The driver issues whole programs (init
// length, cycle on which the core reports done, optional stray Start during
// RUN) and pushes what the host should see into queues; monitors pop and
// compare when CoreInit ends and when Ack rises.
module tb_run_ctrl;

  localparam int MAX_C = 12;
  localparam int NPROG = 3;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        CoreDone;
  logic        CoreInit;
  logic        CoreRun;
  logic [9:0]  ProgBase;
  logic [1:0]  ProgIdx;
  logic        Ack;
  logic        Timeout;
  logic [15:0] CycleCt;

  run_ctrl #(
    .MAX_CYCLES (16'(MAX_C))
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .CoreDone (CoreDone),
    .CoreInit (CoreInit),
    .CoreRun  (CoreRun),
    .ProgBase (ProgBase),
    .ProgIdx  (ProgIdx),
    .Ack      (Ack),
    .Timeout  (Timeout),
    .CycleCt  (CycleCt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int init_n;
    int idx;
  } init_exp_t;

  typedef struct {
    int idx;
    int ct;
    int to;
  } res_exp_t;

  init_exp_t init_q[$];
  res_exp_t  res_q[$];
  int        n_checks = 0;
  int        n_fail   = 0;
  int        run_num  = 0;

  function automatic int exp_base(input int idx);
    return idx * 256;
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_coreinit"}, CoreInit, 0);
    check_output({tag, "_corerun"},  CoreRun,  0);
    check_output({tag, "_ack"},      Ack,      0);
    check_output({tag, "_timeout"},  Timeout,  0);
    check_output({tag, "_cyclect"},  CycleCt,  0);
    check_output({tag, "_progidx"},  ProgIdx,  0);
    check_output({tag, "_progbase"}, ProgBase, 0);
  endtask

  // One full program: Start high for init_n edges, then the core reports
  // done on RUN cycle done_at (never, if done_at exceeds the watchdog).
  task automatic apply_stimulus(input int init_n, input int done_at, input bit poke);
    int idx;
    int last;
    idx  = run_num % NPROG;
    last = (done_at < MAX_C) ? done_at : MAX_C;
    init_q.push_back('{init_n, idx});
    res_q.push_back('{idx, last, (done_at > MAX_C) ? 1 : 0});
    run_num++;
    Start = 1'b1;
    for (int i = 0; i < init_n; i++) begin
      @(posedge Clk); #1;
      CoreDone = 1'($urandom_range(0, 1));
    end
    Start    = 1'b0;
    CoreDone = 1'b0;
    @(posedge Clk); #1;
    for (int j = 1; j <= last; j++) begin
      CoreDone = (j == done_at);
      Start    = poke && (j == 2) && (j < last);
      @(posedge Clk); #1;
    end
    CoreDone = 1'b0;
    Start    = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge Clk); #1;
    end
  endtask

  logic      ack_prev  = 1'b0;
  logic      init_prev = 1'b0;
  int        init_cnt  = 0;
  init_exp_t mon_ie;
  res_exp_t  mon_re;

  // Monitor: compares against the queued expectations on the falling edge.
  always @(negedge Clk) begin
    if (CoreInit && !init_prev) begin
      check_output("ack_low_in_init", Ack, 0);
      check_output("timeout_low_in_init", Timeout, 0);
      init_cnt = 0;
    end
    if (CoreInit) init_cnt++;
    if (!CoreInit && init_prev && !Reset) begin
      if (init_q.size() == 0) begin
        check_output("unexpected_init_end", 1, 0);
      end else begin
        mon_ie = init_q.pop_front();
        check_output("init_len", init_cnt, mon_ie.init_n);
        check_output("init_idx", ProgIdx, mon_ie.idx);
        check_output("init_base", ProgBase, exp_base(mon_ie.idx));
        check_output("run_after_init", CoreRun, 1);
      end
    end
    if (Ack && !ack_prev) begin
      if (res_q.size() == 0) begin
        check_output("unexpected_ack", 1, 0);
      end else begin
        mon_re = res_q.pop_front();
        check_output("done_idx", ProgIdx, mon_re.idx);
        check_output("done_base", ProgBase, exp_base(mon_re.idx));
        check_output("done_cyclect", CycleCt, mon_re.ct);
        check_output("done_timeout", Timeout, mon_re.to);
        check_output("done_corerun", CoreRun, 0);
      end
    end
    ack_prev  = Ack;
    init_prev = CoreInit;
  end

  initial begin
    #200000;
    $display("[TB] FAIL sim_timeout: simulation did not finish in time");
    $fatal(1, "[TB] aborted");
  end

  initial begin
    Reset    = 1'b1;
    Start    = 1'b0;
    CoreDone = 1'b0;
    #2;
    check_all_zero("rst_initial");
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b0;
    @(posedge Clk); #1;
    check_all_zero("idle_after_rst");

    // Basic run, then the rest of the program sequence including the wrap.
    apply_stimulus(3, 10, 1'b0);
    apply_stimulus(2, 4, 1'b0);
    apply_stimulus(1, 7, 1'b1);
    apply_stimulus(2, 3, 1'b0);
    // Done on the watchdog's last cycle, then a pure watchdog, then recovery.
    apply_stimulus(2, MAX_C, 1'b0);
    apply_stimulus(1, MAX_C + 5, 1'b1);
    apply_stimulus(3, 1, 1'b0);

    for (int r = 0; r < 20; r++) begin
      apply_stimulus($urandom_range(1, 4), $urandom_range(1, MAX_C + 4),
                     1'($urandom_range(0, 1)));
    end

    // Reset in the middle of RUN restarts the program sequence at 0.
    init_q.push_back('{2, run_num % NPROG});
    Start = 1'b1;
    repeat (2) begin
      @(posedge Clk); #1;
    end
    Start = 1'b0;
    @(posedge Clk); #1;
    repeat (5) begin
      @(posedge Clk); #1;
    end
    check_output("ct_before_reset", CycleCt, 5);
    #1 Reset = 1'b1;
    #1;
    check_all_zero("rst_mid_run");
    #1 Reset = 1'b0;
    run_num = 0;
    @(posedge Clk); #1;
    apply_stimulus(2, 5, 1'b0);

    repeat (3) @(posedge Clk);
    #1;
    check_output("init_queue_drained", init_q.size(), 0);
    check_output("result_queue_drained", res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
